// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX write port
// between two byte-stream requesters, with a mid-packet stall watchdog.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [1:0]            owner,
    output logic                  abort
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic            last_owner;
    logic            last_owner_next;
    logic [15:0]     idle_cnt;
    logic [15:0]     idle_cnt_next;
    logic            abort_next;

    logic                  sel;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;

    // Only the granted requester's inputs are ever looked at.
    assign sel     = (state == GRANT1);
    assign g_valid = sel ? req1_valid : req0_valid;
    assign g_last  = sel ? req1_last  : req0_last;
    assign g_data  = sel ? req1_data  : req0_data;
    assign owner   = 2'(state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            idle_cnt   <= '0;
            abort      <= 1'b0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            idle_cnt   <= idle_cnt_next;
            abort      <= abort_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        idle_cnt_next   = idle_cnt;
        abort_next      = 1'b0;
        wr_uart         = 1'b0;
        w_data          = '0;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        unique case (state)
            IDLE: begin
                idle_cnt_next = '0;
                if (req0_valid && (!req1_valid || last_owner)) begin
                    state_next = GRANT0;
                end else if (req1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (sel) begin
                    req1_ready = ~tx_full;
                end else begin
                    req0_ready = ~tx_full;
                end
                wr_uart = g_valid & ~tx_full;
                w_data  = g_data;
                // A stalled-but-valid owner is not idle; only a silent one is.
                if (g_valid) begin
                    idle_cnt_next = '0;
                    if (!tx_full && g_last) begin
                        state_next      = IDLE;
                        last_owner_next = sel;
                    end
                end else if (idle_cnt == TIMEOUT_LAST) begin
                    state_next      = IDLE;
                    abort_next      = 1'b1;
                    last_owner_next = sel;
                    idle_cnt_next   = '0;
                end else begin
                    idle_cnt_next = idle_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Two-client arbiter that shares the single UART transmit write port (wr_uart/w_data/tx_full) between two byte-stream requesters. Grants are packet-locked: a requester keeps the port until it sends a byte flagged last. Arbitration between packets is round-robin. A watchdog revokes a grant when the owner stalls mid-packet. The block sits between protocol clients (loopback/echo logic, status reporter) and the uart instance.

Parameters:
DATA_WIDTH, 8, width of each byte lane and of w_data.
TIMEOUT, 1023, consecutive owner-idle cycles mid-packet before the grant is revoked (1..65535).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a byte
req0_data  input  DATA_WIDTH  requester 0 byte
req0_last  input  1  requester 0 byte ends its packet
req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready
req1_valid  input  1  requester 1 has a byte
req1_data  input  DATA_WIDTH  requester 1 byte
req1_last  input  1  requester 1 byte ends its packet
req1_ready  output  1  requester 1 handshake
tx_full  input  1  uart TX FIFO full
wr_uart  output  1  write strobe to uart TX FIFO
w_data  output  DATA_WIDTH  byte to uart TX FIFO
owner  output  2  00 idle, 01 req0 granted, 10 req1 granted
abort  output  1  one-cycle pulse: grant revoked by watchdog

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (ports clk, reset).
- States: IDLE, GRANT0, GRANT1.
- Registered state: state, last_owner (1 bit), idle_cnt (16 bit), abort.
- Reset values: state=IDLE, last_owner=1 (so req0 wins the first contest), idle_cnt=0, abort=0.
- Outputs at reset: owner=00, wr_uart=0, req*_ready=0, w_data=0.
- IDLE transitions:
  - only req0_valid -> GRANT0; only req1_valid -> GRANT1.
  - both valid -> grant the requester != last_owner.
  - no byte is transferred in IDLE, so grant latency is 1 cycle.
- In GRANTn:
  - reqn_ready = ~tx_full; the other requester's ready = 0.
  - wr_uart = reqn_valid & ~tx_full (combinational). Exactly one FIFO write per accepted byte.
  - w_data = reqn_data when granted, else 0.
- Transfer with reqn_last=1 -> IDLE, last_owner<=n, idle_cnt<=0. The next grant needs at least one IDLE cycle.
- Watchdog:
  - In GRANTn, idle_cnt increments on cycles with reqn_valid=0 and clears on any cycle with reqn_valid=1.
  - Cycles stalled by tx_full with valid=1 do not count toward the timeout.
  - When idle_cnt reaches TIMEOUT-1 and valid is still 0 -> IDLE, abort=1 for one cycle, last_owner<=n, idle_cnt<=0.
- owner mirrors state (IDLE=00, GRANT0=01, GRANT1=10).
- Combinational outputs (wr_uart, w_data, req*_ready) depend only on state, tx_full and the granted requester's inputs. They never depend on the other requester.
- tx_full=1 throughout a grant: no writes, no timeout, grant is held indefinitely.
- Valid deasserted on the same cycle the grant starts: counts as an idle cycle.
- Reset mid-packet: immediate return to IDLE with all outputs low; the partial packet is not resumed.

Test Plan:
1. Reset, then req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> owner=01 one cycle after valid; wr_uart high 3 consecutive cycles with w_data 41,42,43; owner=00 after the last byte.
2. req0 and req1 both valid from the same cycle, each with 2-byte packets -> req0 packet sent first, one IDLE cycle, then req1 packet. Repeat -> req1 still alternates with req0 (round-robin holds).
3. During a req1 packet, hold tx_full=1 for 5 cycles with req1_valid=1 -> req1_ready=0 and wr_uart=0 for those 5 cycles; no abort; transfer resumes when tx_full=0.
4. TIMEOUT=8: req0 sends one non-last byte, then drops valid -> abort pulses exactly once, 8 cycles after valid drops; owner=00; a pending req1 is granted on the following cycle.
5. req1 asserts valid with data 0xFF while req0 owns the port -> req1_ready=0 and w_data never shows 0xFF until req0's last byte completes.
6. Assert reset while owner=01 mid-packet -> owner=00, wr_uart=0 immediately (asynchronous); after release, req0 wins again when both requesters are valid.
